// File: rtl/gam_pattern_tx.sv
// gam_pattern_tx: transmit side of the GAM element stream.
// Buffers recalled patterns and their class in a small first-word-fall-through
// FIFO and streams each one as a {class, pattern} element. The element that
// carries the session's last flag is marked with tx_eom. Once it is popped the
// block reports tx_done and waits for a restart pulse.
//
// Ports:
//   clk, reset (async, active-low), restart (1-cycle flush + new session)
//   pat_valid/pat_ready/pat_data/pat_class/pat_last : recall input handshake
//   tx_valid/tx_ready/tx_data/tx_eom                : element output stream
//   tx_count : elements popped since reset/restart, saturating
//   tx_done  : session fully transmitted
//   err_zero : sticky zero-pattern/zero-class flag
//
// Optional feature: define GAM_TX_ZERO_CHECK_EN to build the zero-value check.
// Without it, err_zero is tied low.
module gam_pattern_tx #(
  parameter int unsigned VECTOR_LEN = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       restart,
  input  logic                       pat_valid,
  output logic                       pat_ready,
  input  logic [VECTOR_LEN*8-1:0]    pat_data,
  input  logic [31:0]                pat_class,
  input  logic                       pat_last,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [VECTOR_LEN*8+31:0]   tx_data,
  output logic                       tx_eom,
  output logic [CNT_W-1:0]           tx_count,
  output logic                       tx_done,
  output logic                       err_zero
);

  localparam int unsigned PAT_W   = VECTOR_LEN * 8;
  localparam int unsigned DATA_W  = PAT_W + 32;
  localparam int unsigned ENTRY_W = DATA_W + 1;
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned PW      = AW + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               full_c, empty_c, push_c, pop_c;
  logic [ENTRY_W-1:0] head_c;

  // Pointers carry one extra wrap bit; differing MSBs with equal index means full.
  assign empty_c = (wr_q == rd_q);
  assign full_c  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign pat_ready = !full_c && ((state_q == ST_IDLE) || (state_q == ST_ACTIVE));
  assign tx_valid  = !empty_c && (state_q != ST_DONE);
  assign tx_done   = (state_q == ST_DONE);

  // Any transfer in a restart cycle is discarded.
  assign push_c = pat_valid && pat_ready && !restart;
  assign pop_c  = tx_valid && tx_ready && !restart;

  // Head entry shown straight from storage (first-word-fall-through).
  assign head_c   = mem_q[rd_q[AW-1:0]];
  assign tx_eom   = head_c[ENTRY_W-1];
  assign tx_data  = head_c[DATA_W-1:0];
  assign tx_count = cnt_q;

  // Next-state logic for pointers, counter and session FSM.
  always_comb begin
    wr_d    = wr_q + PW'(push_c);
    rd_d    = rd_q + PW'(pop_c);
    cnt_d   = cnt_q;
    state_d = state_q;
    if (pop_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    case (state_q)
      ST_IDLE: begin
        if (push_c) state_d = pat_last ? ST_DRAIN : ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (push_c && pat_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop_c && head_c[ENTRY_W-1]) state_d = ST_DONE;
      end
      default: begin
        state_d = ST_DONE;
      end
    endcase
    if (restart) begin
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
      state_d = ST_IDLE;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      state_q <= ST_IDLE;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Element storage; cleared on reset so tx_data reads zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push_c) begin
      mem_q[wr_q[AW-1:0]] <= {pat_last, pat_class, pat_data};
    end
  end

`ifdef GAM_TX_ZERO_CHECK_EN
  logic zero_hit_c;
  logic err_zero_q;

  assign zero_hit_c = (pat_data == '0) || (pat_class == '0);
  assign err_zero   = err_zero_q;

  // Sticky until restart; the offending element is still transmitted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_zero_q <= 1'b0;
    end else if (restart) begin
      err_zero_q <= 1'b0;
    end else if (push_c && zero_hit_c) begin
      err_zero_q <= 1'b1;
    end
  end

  // Simulation report of an accepted zero-valued element.
  always_ff @(posedge clk) begin
    if (reset && push_c) begin
      assert (!zero_hit_c)
        else $warning("gam_pattern_tx: zero pattern or class accepted");
    end
  end
`else
  assign err_zero = 1'b0;
`endif

endmodule

// File: tb/tb_gam_pattern_tx.sv
module tb_gam_pattern_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        restart;
  logic        pat_valid;
  logic        pat_ready;
  logic [63:0] pat_data;
  logic [31:0] pat_class;
  logic        pat_last;
  logic        tx_valid;
  logic        tx_ready;
  logic [95:0] tx_data;
  logic        tx_eom;
  logic [15:0] tx_count;
  logic        tx_done;
  logic        err_zero;

  int checks = 0;
  int errors = 0;
  logic [96:0] sb[$];

  always #5 clk = ~clk;

  gam_pattern_tx #(.VECTOR_LEN(8), .FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .reset(rst_n), .restart(restart),
    .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_data(pat_data),
    .pat_class(pat_class), .pat_last(pat_last),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_eom(tx_eom), .tx_count(tx_count), .tx_done(tx_done),
    .err_zero(err_zero)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake that will complete at the next edge pops the scoreboard.
  always @(negedge clk) begin
    if (rst_n && !restart && tx_valid && tx_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got %0h expected no element", {tx_eom, tx_data});
      end else begin
        chk("tx_element", 128'({tx_eom, tx_data}), 128'(sb.pop_front()));
      end
    end
  end

  // Present one pattern; returns the number of extra cycles waited for pat_ready.
  task automatic push(input logic [31:0] cls, input logic [63:0] pat, input logic last,
                      output int waited);
    int n = 0;
    pat_valid = 1'b1;
    pat_class = cls;
    pat_data  = pat;
    pat_last  = last;
    @(negedge clk);
    while (!pat_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!pat_ready) begin
      chk("push_timeout", 128'(n), 128'(0));
    end else begin
      sb.push_back({last, cls, pat});
    end
    waited = n;
    @(posedge clk); #1;
    pat_valid = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    sb.delete();
  endtask

  task automatic wait_done();
    int n = 0;
    while (!tx_done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_timeout", 128'(tx_done), 128'(1));
  endtask

  initial begin
    int w;
    logic [7:0] b;
    logic [95:0] held;
    rst_n = 1'b0; restart = 1'b0; pat_valid = 1'b0; pat_data = '0;
    pat_class = '0; pat_last = 1'b0; tx_ready = 1'b0;
    #2;
    chk("rst_pat_ready", 128'(pat_ready), 128'(1));
    chk("rst_tx_valid",  128'(tx_valid),  128'(0));
    chk("rst_tx_data",   128'(tx_data),   128'(0));
    chk("rst_tx_eom",    128'(tx_eom),    128'(0));
    chk("rst_tx_count",  128'(tx_count),  128'(0));
    chk("rst_tx_done",   128'(tx_done),   128'(0));
    chk("rst_err_zero",  128'(err_zero),  128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single element with last=1.
    push(32'd3, {8{8'hA5}}, 1'b1, w);
    chk("single_valid", 128'(tx_valid), 128'(1));
    chk("single_eom",   128'(tx_eom),   128'(1));
    chk("single_data",  128'(tx_data),  128'({32'd3, {8{8'hA5}}}));
    chk("single_ready", 128'(pat_ready), 128'(0));
    tx_ready = 1'b1;
    wait_done();
    tx_ready = 1'b0;
    chk("single_count", 128'(tx_count), 128'(1));
    chk("single_nvalid", 128'(tx_valid), 128'(0));
    do_restart();
    chk("rs1_count", 128'(tx_count), 128'(0));
    chk("rs1_ready", 128'(pat_ready), 128'(1));
    chk("rs1_done",  128'(tx_done),  128'(0));

    // Back-pressure: fill the FIFO, hold the sink off, data must not move.
    for (int i = 1; i <= 4; i++) begin
      b = 8'(i);
      push(32'(i), {8{b}}, 1'b0, w);
    end
    chk("full_ready", 128'(pat_ready), 128'(0));
    held = tx_data;
    chk("bp_head", 128'(held), 128'({32'd1, {8{8'h01}}}));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_stable", 128'({tx_valid, tx_data}), 128'({1'b1, held}));
    end

    // Full with simultaneous pop and push: slot frees for the next cycle only.
    tx_ready = 1'b1;
    push(32'd5, {8{8'h05}}, 1'b1, w);
    chk("full_push_wait", 128'(w), 128'(1));
    wait_done();
    tx_ready = 1'b0;
    chk("full_count", 128'(tx_count), 128'(5));
    chk("full_sb_empty", 128'(sb.size()), 128'(0));
    do_restart();

    // Saturation of the element counter.
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    chk("sat_forced", 128'(tx_count), 128'(16'hFFFE));
    tx_ready = 1'b1;
    push(32'd7, {8{8'h17}}, 1'b0, w);
    push(32'd8, {8{8'h18}}, 1'b0, w);
    push(32'd9, {8{8'h19}}, 1'b1, w);
    wait_done();
    tx_ready = 1'b0;
    chk("sat_count", 128'(tx_count), 128'(16'hFFFF));
    do_restart();

    // Restart in DRAIN with two elements still queued.
    push(32'd10, {8{8'h2A}}, 1'b0, w);
    push(32'd11, {8{8'h2B}}, 1'b0, w);
    push(32'd12, {8{8'h2C}}, 1'b1, w);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    chk("drain_count1", 128'(tx_count), 128'(1));
    chk("drain_queued", 128'(sb.size()), 128'(2));
    do_restart();
    chk("rsd_valid", 128'(tx_valid), 128'(0));
    chk("rsd_count", 128'(tx_count), 128'(0));
    chk("rsd_ready", 128'(pat_ready), 128'(1));
    chk("rsd_done",  128'(tx_done),  128'(0));

    // Zero-class element: still transmitted; flag behaviour depends on build.
    push(32'd0, {8{8'h3C}}, 1'b1, w);
`ifdef GAM_TX_ZERO_CHECK_EN
    chk("zero_flag_set", 128'(err_zero), 128'(1));
`else
    chk("zero_flag_off", 128'(err_zero), 128'(0));
`endif
    tx_ready = 1'b1;
    wait_done();
    tx_ready = 1'b0;
    chk("zero_sent", 128'(tx_count), 128'(1));
`ifdef GAM_TX_ZERO_CHECK_EN
    chk("zero_flag_sticky", 128'(err_zero), 128'(1));
`else
    chk("zero_flag_still_off", 128'(err_zero), 128'(0));
`endif
    do_restart();
    chk("zero_flag_clr", 128'(err_zero), 128'(0));
    chk("end_sb_empty", 128'(sb.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
